// File: rtl/spi_xfer_arbiter_pkg.sv
// spi_pkg: shared FSM state type and default timing constants for the SPI transfer arbiter
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD, GAP} arb_state_t;
  localparam int CS_SETUP_DEF = 2;
  localparam int CS_GAP_DEF   = 4;
  localparam int TIMEOUT_DEF  = 1024;
endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if: requester byte streams, SPI byte-engine handshake and status of the arbiter
interface spi_xfer_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_data;
  logic [NUM_REQ-1:0]   cs_n;
  logic                 eng_start;
  logic [7:0]           eng_tx_data;
  logic                 eng_done;
  logic [7:0]           eng_rx_data;
  logic                 busy;
  logic [GW-1:0]        gnt_id;
  logic                 err;
  modport slave (
    input  req_valid, req_data, req_last, eng_done, eng_rx_data,
    output req_ready, rsp_valid, rsp_data, cs_n, eng_start, eng_tx_data, busy, gnt_id, err
  );
  modport master (
    output req_valid, req_data, req_last, eng_done, eng_rx_data,
    input  req_ready, rsp_valid, rsp_data, cs_n, eng_start, eng_tx_data, busy, gnt_id, err
  );
endinterface

// File: rtl/spi_xfer_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after ptr
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      gnt,
  output logic               any
);
  logic [NUM_REQ-1:0] rot;
  int off;
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = i;
    any = |req;
    gnt = GW'((int'(ptr) + off >= NUM_REQ) ? int'(ptr) + off - NUM_REQ : int'(ptr) + off);
  end
endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI byte engine with per-requester chip selects and watchdog
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_GAP   = CS_GAP_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst,
  spi_xfer_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2((CS_SETUP > CS_GAP ? CS_SETUP : CS_GAP) + 1);
  localparam int WW = $clog2(TIMEOUT);
  arb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [GW-1:0] gnt_q, gnt_d, rr_q, rr_d, pick;
  logic last_q, last_d, any;
  logic [NUM_REQ-1:0] cs_n_q, cs_n_d, req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, gnt_oh;
  logic [7:0] rsp_data_q, rsp_data_d, eng_tx_q, eng_tx_d;
  logic eng_start_q, eng_start_d, busy_q, busy_d, err_q, err_d, vld_g;
  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (.req(bus.req_valid), .ptr(rr_q), .gnt(pick), .any(any));
  assign gnt_oh = NUM_REQ'(1) << gnt_q;
  assign vld_g  = bus.req_valid[gnt_q];
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    last_d      = last_q;
    cs_n_d      = cs_n_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    eng_start_d = 1'b0;
    eng_tx_d    = eng_tx_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        state_d = SETUP;
        gnt_d   = pick;
        cs_n_d  = ~(NUM_REQ'(1) << pick);
        cnt_d   = '0;
      end
      SETUP: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(CS_SETUP - 1)) ? ISSUE : SETUP;
      end
      ISSUE: begin
        state_d     = WAIT;
        eng_start_d = 1'b1;
        req_ready_d = gnt_oh;
        eng_tx_d    = bus.req_data[8*gnt_q +: 8];
        last_d      = bus.req_last[gnt_q];
        wd_d        = '0;
      end
      // completion wins over a watchdog expiry in the same cycle
      WAIT: if (bus.eng_done) begin
        rsp_valid_d = gnt_oh;
        rsp_data_d  = bus.eng_rx_data;
        state_d     = last_q ? GAP : (vld_g ? ISSUE : HOLD);
      end else if (wd_q == WW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = GAP;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      HOLD: state_d = vld_g ? ISSUE : HOLD;
      GAP: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(CS_GAP - 1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GAP && state_q != GAP) begin
      cs_n_d = '1;
      cnt_d  = '0;
      rr_d   = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      rr_q        <= '0;
      last_q      <= 1'b0;
      cs_n_q      <= '1;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      eng_start_q <= 1'b0;
      eng_tx_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      last_q      <= last_d;
      cs_n_q      <= cs_n_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      eng_start_q <= eng_start_d;
      eng_tx_q    <= eng_tx_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end
  assign bus.cs_n        = cs_n_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_tx_data = eng_tx_q;
  assign bus.busy        = busy_q;
  assign bus.gnt_id      = gnt_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed checks of grant order, CS timing, stalls, watchdog and reset for spi_xfer_arbiter
module tb_spi_xfer_arbiter;
  localparam int N = 4, CS_SETUP = 2, CS_GAP = 4, TIMEOUT = 16;
  typedef struct {int cyc; int id; int data;} ev_t;
  typedef struct {int id; logic [7:0] b0; logic [7:0] b1; int nb; int lat; logic [7:0] r0; logic [7:0] r1;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_xfer_arbiter_if #(.NUM_REQ(N)) bus ();
  spi_xfer_arbiter #(.NUM_REQ(N), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int n_tests = 0, n_fail = 0, cyc = 0, overlap = 0, eng_lat = 2;
  bit eng_en = 1'b1;
  ev_t starts[$], rsps[$], errs[$], falls[$], rises[$];
  logic [8:0] rq [N][$];
  logic [N-1:0] cs_prev;
  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic bit pending();
    pending = bus.busy || (|bus.req_valid);
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) pending = 1'b1;
  endfunction
  task automatic clear_logs();
    starts.delete(); rsps.delete(); errs.delete(); falls.delete(); rises.delete();
  endtask
  task automatic push(int id, bit last, logic [7:0] b);
    rq[id].push_back({last, b});
  endtask
  task automatic wait_idle(int budget, string nm);
    int k = 0;
    while (pending() && k < budget) begin
      tick(1);
      k++;
    end
    chk({nm, "_idle_in_time"}, int'(k < budget), 1);
  endtask
  task automatic wait_ev(bit use_rsp, int n, int budget, string nm);
    int k = 0;
    while (((use_rsp ? rsps.size() : starts.size()) < n) && k < budget) begin
      tick(1);
      k++;
    end
    chk({nm, "_event_in_time"}, int'(k < budget), 1);
  endtask
  task automatic chk_reset_vals(string p);
    chk({p, "_cs_n"}, int'(bus.cs_n), 'hF);
    chk({p, "_busy"}, int'(bus.busy), 0);
    chk({p, "_req_ready"}, int'(bus.req_ready), 0);
    chk({p, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    chk({p, "_rsp_data"}, int'(bus.rsp_data), 0);
    chk({p, "_eng_start"}, int'(bus.eng_start), 0);
    chk({p, "_eng_tx_data"}, int'(bus.eng_tx_data), 0);
    chk({p, "_gnt_id"}, int'(bus.gnt_id), 0);
    chk({p, "_err"}, int'(bus.err), 0);
  endtask
  initial begin
    cs_prev = '1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.eng_start) starts.push_back('{cyc, int'(bus.gnt_id), int'(bus.eng_tx_data)});
      if (bus.err) errs.push_back('{cyc, int'(bus.gnt_id), 0});
      for (int i = 0; i < N; i++) begin
        if (bus.rsp_valid[i]) rsps.push_back('{cyc, i, int'(bus.rsp_data)});
        if (cs_prev[i] && !bus.cs_n[i]) falls.push_back('{cyc, i, 0});
        if (!cs_prev[i] && bus.cs_n[i]) rises.push_back('{cyc, i, 0});
      end
      if ($countones(~bus.cs_n) > 1) overlap++;
      cs_prev = bus.cs_n;
    end
  end
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        bus.req_valid[i]       = rq[i].size() != 0;
        bus.req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0][7:0] : 8'h00;
        bus.req_last[i]        = (rq[i].size() != 0) && rq[i][0][8];
      end
    end
  end
  initial begin
    int pend;
    logic [7:0] tx;
    pend = 0;
    tx = 8'h00;
    bus.eng_done = 1'b0;
    bus.eng_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.eng_done = 1'b1;
          bus.eng_rx_data = {tx[3:0], tx[7:4]};
        end
      end
      if (bus.eng_start && eng_en) begin
        pend = eng_lat;
        tx = bus.eng_tx_data;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at time %0t", $time);
    $fatal(1);
  end
  initial begin
    vec_t tbl[4];
    int ord[4];
    int lowcnt;
    tbl[0] = '{2, 8'hA5, 8'h3C, 2, 3, 8'h5A, 8'hC3};
    tbl[1] = '{0, 8'h12, 8'h00, 1, 1, 8'h21, 8'h00};
    tbl[2] = '{3, 8'hF0, 8'h1E, 2, 5, 8'h0F, 8'hE1};
    tbl[3] = '{1, 8'h80, 8'h00, 1, 2, 8'h08, 8'h00};
    ord = '{0, 1, 3, 0};
    tick(2);
    chk_reset_vals("por");
    rst = 1'b0;
    tick(2);
    for (int t = 0; t < 4; t++) begin
      clear_logs();
      eng_lat = tbl[t].lat;
      push(tbl[t].id, tbl[t].nb == 1, tbl[t].b0);
      if (tbl[t].nb == 2) push(tbl[t].id, 1'b1, tbl[t].b1);
      wait_idle(200, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_starts", t), starts.size(), tbl[t].nb);
      chk($sformatf("tbl%0d_rsps", t), rsps.size(), tbl[t].nb);
      chk($sformatf("tbl%0d_cs_falls", t), falls.size(), 1);
      chk($sformatf("tbl%0d_cs_rises", t), rises.size(), 1);
      chk($sformatf("tbl%0d_gnt_id", t), int'(bus.gnt_id), tbl[t].id);
      chk($sformatf("tbl%0d_cs_idle", t), int'(bus.cs_n), 'hF);
      if (starts.size() == tbl[t].nb && rsps.size() == tbl[t].nb && falls.size() == 1 && rises.size() == 1) begin
        chk($sformatf("tbl%0d_fall_id", t), falls[0].id, tbl[t].id);
        chk($sformatf("tbl%0d_setup_lat", t), starts[0].cyc - falls[0].cyc, CS_SETUP + 1);
        chk($sformatf("tbl%0d_tx0", t), starts[0].data, int'(tbl[t].b0));
        chk($sformatf("tbl%0d_rsp0_id", t), rsps[0].id, tbl[t].id);
        chk($sformatf("tbl%0d_rsp0", t), rsps[0].data, int'(tbl[t].r0));
        chk($sformatf("tbl%0d_rsp_lat", t), rsps[0].cyc - starts[0].cyc, tbl[t].lat + 1);
        chk($sformatf("tbl%0d_cs_rise", t), rises[0].cyc, rsps[tbl[t].nb - 1].cyc);
        if (tbl[t].nb == 2) begin
          chk($sformatf("tbl%0d_tx1", t), starts[1].data, int'(tbl[t].b1));
          chk($sformatf("tbl%0d_rsp1", t), rsps[1].data, int'(tbl[t].r1));
          chk($sformatf("tbl%0d_b2b", t), starts[1].cyc, rsps[0].cyc + 1);
        end
      end
    end
    rst = 1'b1;
    tick(2);
    chk_reset_vals("rst2");
    rst = 1'b0;
    tick(2);
    clear_logs();
    eng_lat = 2;
    push(0, 1'b1, 8'h10);
    push(0, 1'b1, 8'h20);
    push(1, 1'b1, 8'h11);
    push(3, 1'b1, 8'h13);
    wait_idle(400, "cont");
    chk("cont_falls", falls.size(), 4);
    chk("cont_rises", rises.size(), 4);
    chk("cont_rsps", rsps.size(), 4);
    if (falls.size() == 4 && rises.size() == 4 && rsps.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("cont_order%0d", k), falls[k].id, ord[k]);
        if (k > 0) chk($sformatf("cont_gap%0d", k), falls[k].cyc - rises[k-1].cyc, CS_GAP + 1);
      end
      chk("cont_last_rsp", rsps[3].data, 'h02);
    end
    clear_logs();
    push(1, 1'b0, 8'h11);
    wait_ev(1'b1, 1, 100, "stall_first");
    lowcnt = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (bus.cs_n == 4'b1101 && bus.busy) lowcnt++;
    end
    chk("stall_cs_held", lowcnt, 50);
    chk("stall_no_start", starts.size(), 1);
    push(1, 1'b1, 8'h77);
    wait_idle(200, "stall");
    chk("stall_starts", starts.size(), 2);
    chk("stall_rsps", rsps.size(), 2);
    if (starts.size() == 2 && rsps.size() == 2 && rises.size() == 1) begin
      chk("stall_tx", starts[1].data, 'h77);
      chk("stall_rsp", rsps[1].data, 'h77);
      chk("stall_cs_rise", rises[0].cyc, rsps[1].cyc);
    end
    clear_logs();
    eng_en = 1'b0;
    push(0, 1'b1, 8'h55);
    wait_idle(TIMEOUT + 60, "tmo");
    chk("tmo_errs", errs.size(), 1);
    chk("tmo_no_rsp", rsps.size(), 0);
    chk("tmo_busy_after", int'(bus.busy), 0);
    if (errs.size() == 1 && starts.size() == 1 && rises.size() == 1) begin
      chk("tmo_err_lat", errs[0].cyc - starts[0].cyc, TIMEOUT);
      chk("tmo_cs_rise", rises[0].cyc, errs[0].cyc);
    end
    eng_en = 1'b1;
    clear_logs();
    eng_lat = TIMEOUT - 1;
    push(1, 1'b1, 8'hC6);
    wait_idle(TIMEOUT + 60, "bnd");
    chk("bnd_no_err", errs.size(), 0);
    chk("bnd_rsps", rsps.size(), 1);
    if (rsps.size() == 1 && starts.size() == 1) begin
      chk("bnd_rsp", rsps[0].data, 'h6C);
      chk("bnd_rsp_lat", rsps[0].cyc - starts[0].cyc, TIMEOUT);
    end
    clear_logs();
    eng_en = 1'b0;
    push(3, 1'b1, 8'h99);
    wait_ev(1'b0, 1, 100, "wrst_start");
    tick(3);
    rst = 1'b1;
    #1;
    chk_reset_vals("wrst");
    tick(2);
    chk("wrst_starts", starts.size(), 1);
    chk("wrst_rsps", rsps.size(), 0);
    chk("wrst_errs", errs.size(), 0);
    rst = 1'b0;
    eng_en = 1'b1;
    eng_lat = 2;
    clear_logs();
    push(0, 1'b1, 8'h01);
    push(3, 1'b1, 8'h03);
    wait_idle(300, "wrst");
    chk("wrst_falls", falls.size(), 2);
    chk("wrst_rsps_after", rsps.size(), 2);
    if (falls.size() == 2 && rsps.size() == 2) begin
      chk("wrst_first_gnt", falls[0].id, 0);
      chk("wrst_second_gnt", falls[1].id, 3);
      chk("wrst_rsp", rsps[1].data, 'h30);
    end
    chk("cs_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Round-robin arbiter and transaction sequencer that shares one byte-wide SPI master engine among NUM_REQ requesters. It sits between the requester-side byte streams and the SPI byte engine, and owns per-requester active-low chip selects. A multi-byte transaction keeps its grant and chip select until its last byte completes. A watchdog aborts a transfer the engine never finishes.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- CS_SETUP, 2: cycles from cs_n falling to the first eng_start, ≥1.
- CS_GAP, 4: cycles cs_n stays high after a transaction before the next grant, ≥1.
- TIMEOUT, 1024: max cycles from eng_start to eng_done before abort, ≥16.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte in req_data.
- req_data  in  8*NUM_REQ  TX byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  this byte ends requester i's transaction.
- req_ready  out  NUM_REQ  one-hot pulse; byte of requester i accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot pulse; rsp_data holds requester i's RX byte.
- rsp_data  out  8  received byte, valid with rsp_valid.
- cs_n  out  NUM_REQ  per-requester chip select, active low, at most one low.
- eng_start  out  1  one-cycle start pulse to the byte engine.
- eng_tx_data  out  8  byte to send, stable from eng_start until eng_done.
- eng_done  in  1  one-cycle pulse, engine finished the byte.
- eng_rx_data  in  8  received byte, valid with eng_done.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  $clog2(NUM_REQ)  index of current or last grant.
- err  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, HOLD, GAP.
- IDLE: if any req_valid, grant the first valid index at or after rr_ptr (wrapping). Register gnt_id, drive cs_n[gnt] low, go to SETUP. Otherwise stay.
- SETUP: count CS_SETUP cycles, then go to ISSUE.
- ISSUE: requires req_valid[gnt], which is guaranteed on entry.
  - Pulse eng_start and req_ready[gnt] in the same cycle.
  - Latch req_data[gnt] into eng_tx_data and req_last[gnt] into last_r.
  - Clear the watchdog and go to WAIT.
- WAIT, on eng_done:
  - Pulse rsp_valid[gnt] with rsp_data = eng_rx_data.
  - If last_r, go to GAP.
  - Else if req_valid[gnt] in the same cycle, go to ISSUE.
  - Else go to HOLD.
- WAIT, watchdog reaching TIMEOUT-1 without eng_done: pulse err, no rsp_valid, go to GAP.
- HOLD: cs_n[gnt] stays low, no timeout. Go to ISSUE when req_valid[gnt].
- GAP:
  - Entry cycle: cs_n all high, rr_ptr = (gnt_id+1) mod NUM_REQ.
  - Count CS_GAP cycles, then go to IDLE.
- Other requesters' req_valid is ignored while a grant is held.
- Requester rule: req_data/req_last are held while req_valid is high and req_ready is low.
- eng_done outside WAIT is ignored.
- Counters: CS setup/gap counter is $clog2(max(CS_SETUP,CS_GAP)+1) bits; watchdog is $clog2(TIMEOUT) bits, saturating, reset on every ISSUE.

## Timing
- Reset values: cs_n all ones, req_ready 0, rsp_valid 0, rsp_data 0, eng_start 0, eng_tx_data 0, busy 0, gnt_id 0, err 0, rr_ptr 0, state IDLE.
- Reset asserted mid-transfer returns everything to reset values immediately. The engine is not notified; cs_n high ends the slave's frame.
- All outputs are registered. cs_n falls 1 cycle after req_valid is seen in IDLE.
- First eng_start comes CS_SETUP+1 cycles after cs_n falls.
- rsp_valid comes 1 cycle after eng_done.
- Back-to-back byte: next eng_start 2 cycles after eng_done.
- cs_n rises 1 cycle after the last eng_done or after the err pulse.
- Next cs_n fall comes no earlier than CS_GAP+1 cycles after cs_n rises.
- Simultaneous requests in IDLE: the lowest index at or after rr_ptr wins. rr_ptr wraps from NUM_REQ-1 to 0.
- eng_done on the same cycle the watchdog expires counts as completion, not error.

## Structure
- Package spi_pkg holds the arb_state_t enum and default constants CS_SETUP_DEF, CS_GAP_DEF, TIMEOUT_DEF.
- One sub-module, rr_picker: combinational; inputs req vector and rr_ptr; outputs gnt index and any-valid flag.
- The FSM, counters and output registers live in spi_xfer_arbiter.

## Test plan
- Single requester: req 2 sends 0xA5, 0x3C (last), engine echoes 0x5A, 0xC3 → cs_n[2] low for the whole transaction, two eng_starts, rsp_valid[2] carries 0x5A then 0xC3, cs_n returns to 4'b1111.
- Contention: requesters 0, 1, 3 all valid with single-byte last transfers, rr_ptr=0 → grant order 0, 1, 3, then 0; each cs_n low exactly once per grant; no overlap; CS_GAP respected between grants.
- Stall: requester 1 drops req_valid after its first byte → HOLD for 50 cycles with cs_n[1] held low, no eng_start; resumes with 0x77 (last) → one more eng_start, then GAP.
- Timeout: engine never pulses eng_done → err pulse at TIMEOUT cycles after eng_start, no rsp_valid, cs_n high next cycle, arbiter back to IDLE after the gap.
- Reset in WAIT: assert rst mid-byte → cs_n 4'b1111, busy 0, no outputs pulsed. After release, the same requester is granted fresh with rr_ptr=0.
- Boundary: eng_done and watchdog expiry in the same cycle → rsp_valid asserted, err stays 0.
